// File: rtl/perf_pkg.sv
// Shared types for the pipeline performance monitor: FSM states and readout selects.
// No logic; pure type and constant definitions.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_CYCLES  = 2'd0;
    localparam logic [1:0] SEL_RETIRED = 2'd1;
    localparam logic [1:0] SEL_STALLS  = 2'd2;
    localparam logic [1:0] SEL_FLUSHES = 2'd3;

endpackage

// File: rtl/pipe_perf_monitor_if.sv
// Event inputs and valid/ready readout port of the performance monitor.
// Master drives core events and readout requests; slave is the monitor.
interface pipe_perf_monitor_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic             clr_i;
    logic             bubble_i;
    logic             jump_i;
    logic             branch_i;
    logic             flush_i;
    logic             retire_i;
    logic             rd_req_i;
    logic [1:0]       rd_sel_i;
    logic             rd_ready_i;
    logic             rd_valid_o;
    logic [CNT_W-1:0] rd_data_o;
    logic             done_o;

    modport master (
        output start_i, clr_i, bubble_i, jump_i, branch_i, flush_i, retire_i,
        output rd_req_i, rd_sel_i, rd_ready_i,
        input  rd_valid_o, rd_data_o, done_o
    );

    modport slave (
        input  start_i, clr_i, bubble_i, jump_i, branch_i, flush_i, retire_i,
        input  rd_req_i, rd_sel_i, rd_ready_i,
        output rd_valid_o, rd_data_o, done_o
    );
endinterface

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with synchronous clear; value visible one cycle after inc_i.
// No backpressure: sticks at all-ones instead of wrapping.
module perf_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_perf_monitor.sv
// Cycle/retire/stall/flush counters with a cycle-limit DONE state and a snapshot readout.
// Readout valid 1 cycle after accepted request; snapshot held until rd_ready_i, no new request while valid.
module pipe_perf_monitor
    import perf_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 101
) (
    input logic               clk_i,
    input logic               rst_i,
    pipe_perf_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_cnt, ret_cnt, stl_cnt, fls_cnt;
    logic             active;
    logic             hit_limit;
    logic             stall_evt;

    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0] sel_val;
    logic             rd_accept;

    // The IDLE->RUN edge already counts, so counting depends on start_i, not on state==RUN.
    assign active    = bus.start_i && (state_q != DONE) && !bus.clr_i;
    assign hit_limit = active && (cyc_cnt == LAST_CYCLE);
    // A bubble caused by a taken jump/branch is a control bubble, not a hazard stall.
    assign stall_evt = bus.bubble_i && !bus.jump_i && !bus.branch_i;

    always_comb begin
        state_d = state_q;
        if (bus.clr_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) state_d = hit_limit ? DONE : RUN;
                end
                RUN: begin
                    if (!bus.start_i)  state_d = IDLE;
                    else if (hit_limit) state_d = DONE;
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    perf_sat_counter #(.W(CNT_W)) u_cyc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (bus.clr_i),
        .inc_i (active),
        .cnt_o (cyc_cnt)
    );

    perf_sat_counter #(.W(CNT_W)) u_ret (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (bus.clr_i),
        .inc_i (active && bus.retire_i),
        .cnt_o (ret_cnt)
    );

    perf_sat_counter #(.W(CNT_W)) u_stl (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (bus.clr_i),
        .inc_i (active && stall_evt),
        .cnt_o (stl_cnt)
    );

    perf_sat_counter #(.W(CNT_W)) u_fls (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (bus.clr_i),
        .inc_i (active && bus.flush_i),
        .cnt_o (fls_cnt)
    );

    always_comb begin
        sel_val = cyc_cnt;
        unique case (bus.rd_sel_i)
            SEL_CYCLES:  sel_val = cyc_cnt;
            SEL_RETIRED: sel_val = ret_cnt;
            SEL_STALLS:  sel_val = stl_cnt;
            SEL_FLUSHES: sel_val = fls_cnt;
            default:     sel_val = cyc_cnt;
        endcase
    end

    assign rd_accept = bus.rd_req_i && !rd_valid_q && !bus.clr_i;

    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (bus.clr_i) begin
            rd_valid_d = 1'b0;
            rd_data_d  = '0;
        end else if (rd_accept) begin
            rd_valid_d = 1'b1;
            rd_data_d  = sel_val;
        end else if (rd_valid_q && bus.rd_ready_i) begin
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = rd_data_q;
    assign bus.done_o     = (state_q == DONE);
endmodule
